// File: rtl/conv_layer_sequencer.sv
// Per-frame layer sequencer for the super-resolution CNN: walks upsample and conv1..conv5,
// issuing a coefficient load and then an engine run for each layer, with a per-wait watchdog.
module conv_layer_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 65535,
  parameter int NUM_LAYERS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  abort,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  err,
  output logic                  ld_start,
  output logic [ADDR_WIDTH-1:0] ld_wbase,
  output logic [ADDR_WIDTH-1:0] ld_wcount,
  output logic [ADDR_WIDTH-1:0] ld_bbase,
  output logic [ADDR_WIDTH-1:0] ld_bcount,
  input  logic                  ld_done,
  output logic                  eng_start,
  output logic [2:0]            cfg_layer,
  output logic [3:0]            cfg_in_ch,
  output logic [3:0]            cfg_out_ch,
  input  logic                  eng_done,
  output logic [2:0]            dbg_state
);

  // Handshake: ld_start/eng_start are one-cycle command pulses with no back-pressure;
  // ld_done/eng_done are one-cycle completion pulses, honoured only in the matching wait state.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_RUN_REQ   = 3'd3,
    S_RUN_WAIT  = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam int         CW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

  state_t          state, state_n;
  logic [2:0]      layer_n;
  logic            load_cfg;
  logic            frame_done_n;
  logic            err_set, err_clr;
  logic            waiting, timeout;
  logic [CW-1:0]   wd_count;

  logic [3:0]            tbl_in_ch, tbl_out_ch;
  logic [ADDR_WIDTH-1:0] tbl_wbase, tbl_wcount, tbl_bbase, tbl_bcount;

  assign waiting = (state == S_LOAD_WAIT) || (state == S_RUN_WAIT);
  assign timeout = waiting && (wd_count == WD_LIMIT);

  always_comb begin
    state_n      = state;
    layer_n      = cfg_layer;
    load_cfg     = 1'b0;
    frame_done_n = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_n  = S_LOAD_REQ;
          layer_n  = 3'd0;
          load_cfg = 1'b1;
          err_clr  = 1'b1;
        end
      end
      S_LOAD_REQ: state_n = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (ld_done) begin
          state_n = S_RUN_REQ;
        end else if (timeout) begin
          state_n = S_ERROR;
          err_set = 1'b1;
        end
      end
      S_RUN_REQ: state_n = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (eng_done) begin
          if (cfg_layer == LAST_LAYER) begin
            state_n      = S_IDLE;
            frame_done_n = 1'b1;
          end else begin
            state_n  = S_LOAD_REQ;
            layer_n  = cfg_layer + 3'd1;
            load_cfg = 1'b1;
          end
        end else if (timeout) begin
          state_n = S_ERROR;
          err_set = 1'b1;
        end
      end
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort overrides every transition out of a busy state and leaves err untouched
    if (abort && (state != S_IDLE)) begin
      state_n      = S_IDLE;
      layer_n      = cfg_layer;
      load_cfg     = 1'b0;
      frame_done_n = 1'b0;
      err_set      = 1'b0;
    end
  end

  always_comb begin
    tbl_in_ch  = 4'd0;
    tbl_out_ch = 4'd0;
    tbl_wbase  = '0;
    tbl_wcount = '0;
    tbl_bbase  = '0;
    tbl_bcount = '0;
    unique case (layer_n)
      3'd0: begin
        tbl_in_ch = 4'd3; tbl_out_ch = 4'd12;
        tbl_wbase = ADDR_WIDTH'(0);    tbl_wcount = ADDR_WIDTH'(324);
        tbl_bbase = ADDR_WIDTH'(324);  tbl_bcount = ADDR_WIDTH'(12);
      end
      3'd1: begin
        tbl_in_ch = 4'd3; tbl_out_ch = 4'd9;
        tbl_wbase = ADDR_WIDTH'(336);  tbl_wcount = ADDR_WIDTH'(243);
        tbl_bbase = ADDR_WIDTH'(579);  tbl_bcount = ADDR_WIDTH'(9);
      end
      3'd2: begin
        tbl_in_ch = 4'd9; tbl_out_ch = 4'd9;
        tbl_wbase = ADDR_WIDTH'(588);  tbl_wcount = ADDR_WIDTH'(729);
        tbl_bbase = ADDR_WIDTH'(1317); tbl_bcount = ADDR_WIDTH'(9);
      end
      3'd3: begin
        tbl_in_ch = 4'd9; tbl_out_ch = 4'd9;
        tbl_wbase = ADDR_WIDTH'(1326); tbl_wcount = ADDR_WIDTH'(729);
        tbl_bbase = ADDR_WIDTH'(2055); tbl_bcount = ADDR_WIDTH'(9);
      end
      3'd4: begin
        tbl_in_ch = 4'd9; tbl_out_ch = 4'd9;
        tbl_wbase = ADDR_WIDTH'(2064); tbl_wcount = ADDR_WIDTH'(729);
        tbl_bbase = ADDR_WIDTH'(2793); tbl_bcount = ADDR_WIDTH'(9);
      end
      3'd5: begin
        tbl_in_ch = 4'd9; tbl_out_ch = 4'd3;
        tbl_wbase = ADDR_WIDTH'(2802); tbl_wcount = ADDR_WIDTH'(243);
        tbl_bbase = ADDR_WIDTH'(3045); tbl_bcount = ADDR_WIDTH'(3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
      err        <= 1'b0;
      wd_count   <= '0;
      cfg_layer  <= 3'd0;
      cfg_in_ch  <= 4'd0;
      cfg_out_ch <= 4'd0;
      ld_wbase   <= '0;
      ld_wcount  <= '0;
      ld_bbase   <= '0;
      ld_bcount  <= '0;
    end else begin
      state      <= state_n;
      frame_done <= frame_done_n;
      if (err_clr) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      // Watchdog only runs inside a wait state; any other state rearms it
      if (!waiting) begin
        wd_count <= '0;
      end else if (!timeout) begin
        wd_count <= wd_count + 1'b1;
      end
      if (load_cfg) begin
        cfg_layer  <= layer_n;
        cfg_in_ch  <= tbl_in_ch;
        cfg_out_ch <= tbl_out_ch;
        ld_wbase   <= tbl_wbase;
        ld_wcount  <= tbl_wcount;
        ld_bbase   <= tbl_bbase;
        ld_bcount  <= tbl_bcount;
      end
    end
  end

  assign ld_start   = (state == S_LOAD_REQ);
  assign eng_start  = (state == S_RUN_REQ);
  assign frame_busy = (state == S_LOAD_REQ) || (state == S_LOAD_WAIT) ||
                      (state == S_RUN_REQ)  || (state == S_RUN_WAIT);
  assign dbg_state  = state;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: behavioural loader/engine responders, a negedge
// monitor that logs every command, and per-scenario tasks with hand-computed expectations.
module tb_conv_layer_sequencer;

  localparam int AW = 16;

  logic          clk, reset, frame_start, abort;
  logic          frame_busy, frame_done, err, ld_start, ld_done, eng_start, eng_done;
  logic [AW-1:0] ld_wbase, ld_wcount, ld_bbase, ld_bcount;
  logic [2:0]    cfg_layer, dbg_state;
  logic [3:0]    cfg_in_ch, cfg_out_ch;
  logic          eng_done_auto, eng_done_spur;

  assign eng_done = eng_done_auto | eng_done_spur;

  conv_layer_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(100), .NUM_LAYERS(6)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
    .frame_busy(frame_busy), .frame_done(frame_done), .err(err),
    .ld_start(ld_start), .ld_wbase(ld_wbase), .ld_wcount(ld_wcount),
    .ld_bbase(ld_bbase), .ld_bcount(ld_bcount), .ld_done(ld_done),
    .eng_start(eng_start), .cfg_layer(cfg_layer), .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch), .eng_done(eng_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int ld_lat = 5;
  int eng_lat = 5;
  int ld_skip_layer = -1;
  int n_ld, n_eng, n_fd;
  int fd_cyc, ed_cyc, err_rise_cyc, busy_fall_cyc;
  logic err_d, busy_d;
  int ld_cyc_q[$];
  int eng_cyc_q[$];
  logic [74:0] log_q[$];
  logic [74:0] exp_q[$];

  function automatic logic [74:0] exp_entry(input int i);
    logic [74:0] e;
    case (i)
      0: e = {3'd0, 4'd3, 4'd12, 16'd0,    16'd324, 16'd324,  16'd12};
      1: e = {3'd1, 4'd3, 4'd9,  16'd336,  16'd243, 16'd579,  16'd9};
      2: e = {3'd2, 4'd9, 4'd9,  16'd588,  16'd729, 16'd1317, 16'd9};
      3: e = {3'd3, 4'd9, 4'd9,  16'd1326, 16'd729, 16'd2055, 16'd9};
      4: e = {3'd4, 4'd9, 4'd9,  16'd2064, 16'd729, 16'd2793, 16'd9};
      default: e = {3'd5, 4'd9, 4'd3, 16'd2802, 16'd243, 16'd3045, 16'd3};
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    err_d = 1'b0;
    busy_d = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_start) begin
        n_ld++;
        ld_cyc_q.push_back(cyc);
        log_q.push_back({cfg_layer, cfg_in_ch, cfg_out_ch, ld_wbase, ld_wcount, ld_bbase, ld_bcount});
      end
      if (eng_start) begin
        n_eng++;
        eng_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (eng_done) ed_cyc = cyc;
      if (err && !err_d) err_rise_cyc = cyc;
      if (!frame_busy && busy_d) busy_fall_cyc = cyc;
      err_d = err;
      busy_d = frame_busy;
    end
  end

  // ---------------- responders (driver side) ----------------
  initial begin : loader_model
    ld_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_start && !reset && (int'(cfg_layer) != ld_skip_layer)) begin
        repeat (ld_lat) @(posedge clk);
        #1 ld_done = 1'b1;
        @(posedge clk);
        #1 ld_done = 1'b0;
      end
    end
  end

  initial begin : engine_model
    eng_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start && !reset) begin
        repeat (eng_lat) @(posedge clk);
        #1 eng_done_auto = 1'b1;
        @(posedge clk);
        #1 eng_done_auto = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    n_ld = 0; n_eng = 0; n_fd = 0;
    fd_cyc = -1; ed_cyc = -1; err_rise_cyc = -1; busy_fall_cyc = -1;
    ld_cyc_q = {}; eng_cyc_q = {}; log_q = {};
  endtask

  task automatic start_frame(output int s);
    @(posedge clk);
    #1 frame_start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int k = 0;
    while (n_fd < target && k < budget) begin
      tick();
      k++;
    end
    if (n_fd < target) begin
      total++; bad++;
      $display("FAIL wait_frame_done: got %0d pulses, need %0d", n_fd, target);
    end
  endtask

  task automatic check_layer_log(input string tag);
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_entry(i));
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= log_q.size()) begin
        bad++;
        $display("FAIL %s_layer%0d: no ld_start logged, expected %h", tag, i, exp_q[i]);
      end else if (log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_layer%0d: got %h expected %h", tag, i, log_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({frame_busy, frame_done, err, ld_start, eng_start, ld_wbase, ld_wcount, ld_bbase,
         ld_bcount, cfg_layer, cfg_in_ch, cfg_out_ch} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero (busy=%b wbase=%0d layer=%0d) expected all 0",
               frame_busy, ld_wbase, cfg_layer);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b0;
    clear_logs();
    repeat (5) tick();
    total++;
    if (frame_busy !== 1'b0 || n_ld !== 0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b ld_starts=%0d expected 0/0", frame_busy, n_ld);
    end
  endtask

  task automatic test_nominal();
    int s;
    ld_lat = 5; eng_lat = 5;
    clear_logs();
    start_frame(s);
    wait_fd(1, 400);
    tick();
    total++;
    if (n_ld !== 6 || n_eng !== 6) begin
      bad++;
      $display("FAIL nominal_counts: ld=%0d eng=%0d expected 6/6", n_ld, n_eng);
    end
    check_layer_log("nominal");
    total++;
    if (fd_cyc !== ed_cyc + 1) begin
      bad++;
      $display("FAIL nominal_done_lat: frame_done cycle %0d, expected %0d", fd_cyc, ed_cyc + 1);
    end
    total++;
    if (busy_fall_cyc !== fd_cyc) begin
      bad++;
      $display("FAIL nominal_busy_fall: cycle %0d expected %0d", busy_fall_cyc, fd_cyc);
    end
    total++;
    if (n_fd !== 1 || err !== 1'b0 || frame_busy !== 1'b0) begin
      bad++;
      $display("FAIL nominal_end: fd=%0d err=%b busy=%b expected 1/0/0", n_fd, err, frame_busy);
    end
    total++;
    if (cfg_layer !== 3'd5 || ld_wbase !== 16'd2802 || ld_bbase !== 16'd3045 || cfg_out_ch !== 4'd3) begin
      bad++;
      $display("FAIL nominal_idle_hold: layer=%0d wbase=%0d bbase=%0d out=%0d expected 5/2802/3045/3",
               cfg_layer, ld_wbase, ld_bbase, cfg_out_ch);
    end
  endtask

  task automatic test_zero_latency();
    int s;
    ld_lat = 1; eng_lat = 1;
    clear_logs();
    start_frame(s);
    wait_fd(1, 200);
    total++;
    if (fd_cyc - s !== 25) begin
      bad++;
      $display("FAIL zero_lat_total: got %0d cycles expected 25", fd_cyc - s);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= ld_cyc_q.size()) begin
        bad++;
        $display("FAIL zero_lat_spacing%0d: missing ld_start", i);
      end else if (ld_cyc_q[i] - s !== 1 + 4 * i) begin
        bad++;
        $display("FAIL zero_lat_spacing%0d: offset %0d expected %0d", i, ld_cyc_q[i] - s, 1 + 4 * i);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_watchdog();
    int s;
    int k;
    ld_lat = 5; eng_lat = 5; ld_skip_layer = 2;
    clear_logs();
    start_frame(s);
    k = 0;
    while (err !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    total++;
    if (ld_cyc_q.size() < 3 || err_rise_cyc - ld_cyc_q[2] !== 102) begin
      bad++;
      $display("FAIL wd_err_rise: err rise cycle %0d, ld_starts %0d, expected 102 after layer-2 ld_start",
               err_rise_cyc, ld_cyc_q.size());
    end
    total++;
    if (busy_fall_cyc !== err_rise_cyc) begin
      bad++;
      $display("FAIL wd_busy_fall: cycle %0d expected %0d", busy_fall_cyc, err_rise_cyc);
    end
    repeat (3) tick();
    total++;
    if (n_fd !== 0 || n_ld !== 3 || dbg_state !== 3'd0 || err !== 1'b1) begin
      bad++;
      $display("FAIL wd_after: fd=%0d ld=%0d state=%0d err=%b expected 0/3/0/1",
               n_fd, n_ld, dbg_state, err);
    end
    ld_skip_layer = -1;
    ld_lat = 1; eng_lat = 1;
    clear_logs();
    start_frame(s);
    tick();
    total++;
    if (err !== 1'b0 || frame_busy !== 1'b1) begin
      bad++;
      $display("FAIL wd_restart_clear: err=%b busy=%b expected 0/1", err, frame_busy);
    end
    wait_fd(1, 200);
    total++;
    if (n_ld !== 6 || err !== 1'b0) begin
      bad++;
      $display("FAIL wd_restart_run: ld=%0d err=%b expected 6/0", n_ld, err);
    end
    repeat (4) tick();
  endtask

  task automatic test_abort();
    int s;
    int k;
    ld_lat = 5; eng_lat = 5;
    clear_logs();
    start_frame(s);
    k = 0;
    while (!(eng_start === 1'b1 && cfg_layer === 3'd3) && k < 300) begin
      tick();
      k++;
    end
    total++;
    if (k >= 300) begin
      bad++;
      $display("FAIL abort_reach_layer3: layer 3 eng_start not seen");
    end
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    tick();
    total++;
    if (frame_busy !== 1'b0 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL abort_busy: busy=%b state=%0d expected 0/0", frame_busy, dbg_state);
    end
    repeat (20) tick();
    total++;
    if (n_ld !== 4 || n_eng !== 4 || n_fd !== 0 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: ld=%0d eng=%0d fd=%0d err=%b expected 4/4/0/0",
               n_ld, n_eng, n_fd, err);
    end
    clear_logs();
    start_frame(s);
    wait_fd(1, 400);
    check_layer_log("abort_restart");
    repeat (4) tick();
  endtask

  task automatic test_spurious();
    int s;
    ld_lat = 5; eng_lat = 5;
    clear_logs();
    start_frame(s);
    @(posedge clk);
    #1 eng_done_spur = 1'b1; frame_start = 1'b1;
    @(posedge clk);
    #1 eng_done_spur = 1'b0; frame_start = 1'b0;
    tick();
    total++;
    if (dbg_state !== 3'd2 || frame_busy !== 1'b1) begin
      bad++;
      $display("FAIL spurious_state: state=%0d busy=%b expected 2/1", dbg_state, frame_busy);
    end
    wait_fd(1, 400);
    tick();
    total++;
    if (eng_cyc_q.size() < 1 || eng_cyc_q[0] - s !== 7) begin
      bad++;
      $display("FAIL spurious_first_eng: offset %0d expected 7",
               (eng_cyc_q.size() > 0) ? eng_cyc_q[0] - s : -1);
    end
    total++;
    if (n_ld !== 6 || n_eng !== 6 || n_fd !== 1) begin
      bad++;
      $display("FAIL spurious_counts: ld=%0d eng=%0d fd=%0d expected 6/6/1", n_ld, n_eng, n_fd);
    end
    check_layer_log("spurious");
    repeat (4) tick();
  endtask

  task automatic test_reset_midframe();
    int s;
    int snap;
    ld_lat = 5; eng_lat = 5;
    clear_logs();
    start_frame(s);
    repeat (15) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({frame_busy, frame_done, err, ld_start, eng_start, ld_wbase, ld_wcount, ld_bbase,
         ld_bcount, cfg_layer, cfg_in_ch, cfg_out_ch, dbg_state} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: busy=%b layer=%0d wbase=%0d state=%0d expected all 0",
               frame_busy, cfg_layer, ld_wbase, dbg_state);
    end
    repeat (2) tick();
    reset = 1'b0;
    snap = n_ld;
    repeat (30) tick();
    total++;
    if (n_ld !== snap || frame_busy !== 1'b0 || n_fd !== 0 || dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL midreset_idle: ld %0d->%0d busy=%b fd=%0d state=%0d expected no activity",
               snap, n_ld, frame_busy, n_fd, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    abort = 1'b0;
    eng_done_spur = 1'b0;
    test_reset();
    test_nominal();
    test_zero_latency();
    test_watchdog();
    test_abort();
    test_spurious();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Per-frame controller for the super-resolution CNN pipeline. It steps through the six network layers: upsample, then conv1 to conv5. For each layer it commands the weight/bias loader to fetch that layer's coefficients from the shared coefficient ROM, then starts the convolution engine with the layer's channel configuration. It sits between the frame-level control (video timing / host) and the weight loader plus convolution engine. It also provides a per-wait watchdog and an abort path.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of ROM base addresses and counts
- TIMEOUT, 65535, max cycles allowed in any wait state before error
- NUM_LAYERS, 6, layers per frame (fixed table below; values other than 6 unsupported)

Ports (reset is asynchronous and active-high; the clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse; begin a frame sequence (ignored unless IDLE)
- abort  in  1  level; synchronous abort of the current sequence
- frame_busy  out  1  high from accepted frame_start until completion, abort or error
- frame_done  out  1  one-cycle pulse on successful completion of all layers
- err  out  1  sticky watchdog error flag
- ld_start  out  1  one-cycle pulse; loader command valid
- ld_wbase  out  ADDR_WIDTH  weight base address for the current layer
- ld_wcount  out  ADDR_WIDTH  weight word count
- ld_bbase  out  ADDR_WIDTH  bias base address
- ld_bcount  out  ADDR_WIDTH  bias word count
- ld_done  in  1  one-cycle pulse from loader; coefficients resident
- eng_start  out  1  one-cycle pulse; start convolution engine
- cfg_layer  out  3  current layer index, 0 to 5
- cfg_in_ch  out  4  input channels of the current layer
- cfg_out_ch  out  4  output channels of the current layer
- eng_done  in  1  one-cycle pulse; engine finished the layer

## Operation
Layer table (index: in_ch / out_ch, wbase / wcount, bbase / bcount):
- 0 upsample: 3 / 12, 0 / 324, 324 / 12
- 1 conv1: 3 / 9, 336 / 243, 579 / 9
- 2 conv2: 9 / 9, 588 / 729, 1317 / 9
- 3 conv3: 9 / 9, 1326 / 729, 2055 / 9
- 4 conv4: 9 / 9, 2064 / 729, 2793 / 9
- 5 conv5: 9 / 3, 2802 / 243, 3045 / 3
- Total ROM footprint is 3048 words. Table values are constants zero-extended to the port widths.

FSM states:
- IDLE: on frame_start, set layer to 0, clear err, set frame_busy, go to LOAD_REQ.
- LOAD_REQ: pulse ld_start for exactly one cycle with the table values of the current layer; clear the watchdog; go to LOAD_WAIT.
- LOAD_WAIT: on ld_done go to RUN_REQ.
- RUN_REQ: pulse eng_start for one cycle; clear the watchdog; go to RUN_WAIT.
- RUN_WAIT: on eng_done:
  - if layer == 5, go to IDLE, pulse frame_done and drop frame_busy;
  - otherwise increment layer and go to LOAD_REQ.
- ERROR: entered from LOAD_WAIT or RUN_WAIT when the watchdog reaches TIMEOUT with no done seen. Set err, drop frame_busy, go to IDLE on the following cycle. err stays high until the next accepted frame_start or reset.

Output and input rules:
- ld_wbase, ld_wcount, ld_bbase, ld_bcount, cfg_in_ch, cfg_out_ch and cfg_layer are registered. They always reflect the current layer and hold stable from LOAD_REQ through RUN_WAIT.
- In IDLE these outputs hold the values of the last layer executed.
- Abort has priority over all transitions in any non-IDLE state. Next state is IDLE, frame_busy drops, and no frame_done is pulsed. A start pulse scheduled in the same cycle is suppressed. err is unchanged.
- ld_done or eng_done arriving in a state that is not waiting for it is ignored.
- frame_start while busy is ignored.
- Done and timeout in the same cycle: done wins.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- frame_start is sampled at edge N. ld_start is high during cycle N+1.
- ld_done sampled at edge M gives eng_start high in cycle M+1.
- eng_done sampled at edge K gives one of:
  - next ld_start in cycle K+1, or
  - for the last layer, frame_done in cycle K+1 and frame_busy low from K+1.
- Controller overhead is 2 cycles per layer, plus 1 cycle at frame start.
- The watchdog counts cycles spent in a wait state. Timeout fires on the cycle where count == TIMEOUT. The next state is ERROR; err is visible 1 cycle later and frame_busy is low at the same time.
- Abort sampled at edge A gives frame_busy low from cycle A+1.

## Test plan
- Nominal frame: loader and engine reply with 5-cycle latencies → exactly 6 ld_start and 6 eng_start pulses. ld_wbase sequence is 0, 336, 588, 1326, 2064, 2802. cfg_in_ch/cfg_out_ch sequence is 3/12, 3/9, 9/9, 9/9, 9/9, 9/3. One frame_done pulse follows the 6th eng_done by 1 cycle.
- Zero-latency responders: ld_done arrives in the cycle right after ld_start → per-layer spacing is 4 cycles; total from frame_start to frame_done is 25 cycles.
- Watchdog: TIMEOUT=100 and ld_done withheld in layer 2 → err rises 102 cycles after the layer-2 ld_start. frame_busy falls together with err and there is no frame_done. A following frame_start clears err.
- Abort during RUN_WAIT of layer 3 → frame_busy is low next cycle, no further starts occur, err stays 0. A new frame_start restarts at layer 0.
- Spurious inputs: eng_done during LOAD_WAIT and frame_start while busy → no state change and no extra pulses.
- Reset asserted asynchronously in mid-frame → all outputs are 0 immediately. After release, the block is idle until frame_start.
